// File: rtl/board_draw_controller_if.sv
// Request/pixel bundle between a board-draw requester and the draw controller.
// The requester supplies the grid and draw requests; the controller returns
// VGA pixel writes plus busy/done status.
interface board_draw_controller_if;
  logic [17:0] grid;
  logic        start;
  logic        start_one;
  logic [3:0]  cell_idx;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output grid, start, start_one, cell_idx,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  grid, start, start_one, cell_idx,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/board_draw_controller.sv
// Tic-tac-toe board renderer for a 160x120 VGA pixel plane.
// A request snapshots the grid, then one filled square per cell is rastered
// out one pixel per clock. Every output comes straight from a register, so
// pixel values for the next cycle are computed from the next counter values.
module board_draw_controller #(
  parameter int CELL_SIZE = 25,
  parameter int X_ORIGIN  = 37,
  parameter int Y_ORIGIN  = 7,
  parameter int PITCH     = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  board_draw_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_PX  = 5'(CELL_SIZE - 1);
  localparam logic [3:0] MAX_CELL = 4'd8;

  // Column (cell mod 3) of a row-major cell index.
  function automatic logic [1:0] cell_col(input logic [3:0] c);
    case (c)
      4'd0, 4'd3, 4'd6: cell_col = 2'd0;
      4'd1, 4'd4, 4'd7: cell_col = 2'd1;
      4'd2, 4'd5, 4'd8: cell_col = 2'd2;
      default:          cell_col = 2'd0;
    endcase
  endfunction

  // Row (cell div 3) of a row-major cell index.
  function automatic logic [1:0] cell_row(input logic [3:0] c);
    case (c)
      4'd0, 4'd1, 4'd2: cell_row = 2'd0;
      4'd3, 4'd4, 4'd5: cell_row = 2'd1;
      4'd6, 4'd7, 4'd8: cell_row = 2'd2;
      default:          cell_row = 2'd0;
    endcase
  endfunction

  // Screen x of pixel column px inside cell c.
  function automatic logic [7:0] pixel_x(input logic [3:0] c, input logic [4:0] px);
    logic [7:0] off;
    case (cell_col(c))
      2'd1:    off = 8'(PITCH);
      2'd2:    off = 8'(2 * PITCH);
      default: off = 8'd0;
    endcase
    pixel_x = 8'(X_ORIGIN) + off + {3'b000, px};
  endfunction

  // Screen y of pixel row py inside cell c.
  function automatic logic [6:0] pixel_y(input logic [3:0] c, input logic [4:0] py);
    logic [6:0] off;
    case (cell_row(c))
      2'd1:    off = 7'(PITCH);
      2'd2:    off = 7'(2 * PITCH);
      default: off = 7'd0;
    endcase
    pixel_y = 7'(Y_ORIGIN) + off + {2'b00, py};
  endfunction

  // Two-bit occupancy code of cell c; cell 0 sits in the top bits.
  function automatic logic [1:0] cell_code(input logic [17:0] g, input logic [3:0] c);
    case (c)
      4'd0:    cell_code = g[17:16];
      4'd1:    cell_code = g[15:14];
      4'd2:    cell_code = g[13:12];
      4'd3:    cell_code = g[11:10];
      4'd4:    cell_code = g[9:8];
      4'd5:    cell_code = g[7:6];
      4'd6:    cell_code = g[5:4];
      4'd7:    cell_code = g[3:2];
      4'd8:    cell_code = g[1:0];
      default: cell_code = 2'b00;
    endcase
  endfunction

  // Empty is white, O is cyan, X is magenta; the unused code paints black.
  function automatic logic [2:0] code_colour(input logic [1:0] code);
    case (code)
      2'd0:    code_colour = 3'b111;
      2'd1:    code_colour = 3'b011;
      2'd2:    code_colour = 3'b101;
      default: code_colour = 3'b000;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [17:0] snap_r, snap_s;
  logic [3:0]  cell_r, cell_s;
  logic [3:0]  last_cell_r, last_cell_s;
  logic [4:0]  px_r, px_s;
  logic [4:0]  py_r, py_s;
  logic [7:0]  x_r, x_s;
  logic [6:0]  y_r, y_s;
  logic [2:0]  colour_r, colour_s;
  logic        plot_r, plot_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        draw_s;

  // Next-state, raster counters, and the pixel to present on the next cycle.
  always_comb begin
    state_s     = state_r;
    snap_s      = snap_r;
    cell_s      = cell_r;
    last_cell_s = last_cell_r;
    px_s        = px_r;
    py_s        = py_r;
    draw_s      = 1'b0;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s     = DRAW;
          snap_s      = bus.grid;
          cell_s      = 4'd0;
          last_cell_s = MAX_CELL;
          px_s        = 5'd0;
          py_s        = 5'd0;
          draw_s      = 1'b1;
        end else if (bus.start_one && (bus.cell_idx <= MAX_CELL)) begin
          state_s     = DRAW;
          snap_s      = bus.grid;
          cell_s      = bus.cell_idx;
          last_cell_s = bus.cell_idx;
          px_s        = 5'd0;
          py_s        = 5'd0;
          draw_s      = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (px_r != LAST_PX) begin
          px_s   = px_r + 5'd1;
          draw_s = 1'b1;
        end else if (py_r != LAST_PX) begin
          px_s   = 5'd0;
          py_s   = py_r + 5'd1;
          draw_s = 1'b1;
        end else if (cell_r == last_cell_r) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          cell_s = cell_r + 4'd1;
          px_s   = 5'd0;
          py_s   = 5'd0;
          draw_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (draw_s) begin
      x_s      = pixel_x(cell_s, px_s);
      y_s      = pixel_y(cell_s, py_s);
      colour_s = code_colour(cell_code(snap_s, cell_s));
      plot_s   = 1'b1;
      busy_s   = 1'b1;
    end else begin
      x_s      = x_r;
      y_s      = y_r;
      colour_s = colour_r;
      plot_s   = 1'b0;
      busy_s   = 1'b0;
    end
  end

  // State, snapshot, counters and output registers; reset clears at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      snap_r      <= 18'd0;
      cell_r      <= 4'd0;
      last_cell_r <= 4'd0;
      px_r        <= 5'd0;
      py_r        <= 5'd0;
      x_r         <= 8'd0;
      y_r         <= 7'd0;
      colour_r    <= 3'd0;
      plot_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      snap_r      <= snap_s;
      cell_r      <= cell_s;
      last_cell_r <= last_cell_s;
      px_r        <= px_s;
      py_r        <= py_s;
      x_r         <= x_s;
      y_r         <= y_s;
      colour_r    <= colour_s;
      plot_r      <= plot_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign bus.x      = x_r;
  assign bus.y      = y_r;
  assign bus.colour = colour_r;
  assign bus.plot   = plot_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_board_draw_controller.sv
// Bench for board_draw_controller. A behavioural model expands each accepted
// request into the full list of expected per-cycle outputs; a compare process
// checks the DUT against that list on every falling edge, and directed tests
// pin the model with hand-computed pixel coordinates, colours and counts.
module tb_board_draw_controller;

  localparam int CS = 25;
  localparam int XO = 37;
  localparam int YO = 7;
  localparam int P  = 30;

  localparam logic [17:0] MIXED = 18'b01_10_00_00_01_00_10_00_01;

  logic clock;
  logic reset;

  board_draw_controller_if bus ();

  board_draw_controller #(
    .CELL_SIZE(CS),
    .X_ORIGIN (XO),
    .Y_ORIGIN (YO),
    .PITCH    (P)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit pix;
    bit plot;
    bit busy;
    bit done;
    int x;
    int y;
    int colour;
  } rec_t;

  rec_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int s_cnt, s_fx, s_fy, s_lx, s_ly, s_lc;
  int s_minx, s_maxx, s_miny, s_maxy, s_probe, s_dones;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int colour_of(input int code);
    if (code == 0) return 7;
    else if (code == 1) return 3;
    else if (code == 2) return 5;
    else return 0;
  endfunction

  // Model: a request issued while the model is idle becomes one idle cycle,
  // the raster of every requested cell, then one done cycle.
  function automatic void model_request(input bit s, input bit so, input int idx,
                                        input logic [17:0] g);
    int   first;
    int   last;
    int   code;
    rec_t r;
    if (exp_q.size() != 0) return;
    if (s) begin
      first = 0;
      last  = 8;
    end else if (so && idx <= 8) begin
      first = idx;
      last  = idx;
    end else begin
      return;
    end
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    exp_q.push_back(r);
    for (int c = first; c <= last; c++) begin
      code = (int'(g) >> (16 - 2 * c)) & 3;
      for (int py = 0; py < CS; py++) begin
        for (int px = 0; px < CS; px++) begin
          r = '{1'b1, 1'b1, 1'b1, 1'b0, XO + (c % 3) * P + px, YO + (c / 3) * P + py,
                colour_of(code)};
          exp_q.push_back(r);
        end
      end
    end
    r = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0};
    exp_q.push_back(r);
  endfunction

  // Compare DUT against the model every falling edge and gather pixel stats.
  always @(negedge clock) begin
    rec_t r;
    if (!reset) begin
      if (exp_q.size() > 0) r = exp_q.pop_front();
      else r = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
      if (r.pix)
        chk("pixel", 32'({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}),
            32'({r.plot, r.busy, r.done, 8'(r.x), 7'(r.y), 3'(r.colour)}));
      else
        chk("control", 32'({bus.plot, bus.busy, bus.done}), 32'({r.plot, r.busy, r.done}));
      if (bus.plot === 1'b1) begin
        if (s_cnt == 0) begin
          s_fx = int'(bus.x);
          s_fy = int'(bus.y);
        end
        s_lx = int'(bus.x);
        s_ly = int'(bus.y);
        s_lc = int'(bus.colour);
        if (int'(bus.x) < s_minx) s_minx = int'(bus.x);
        if (int'(bus.x) > s_maxx) s_maxx = int'(bus.x);
        if (int'(bus.y) < s_miny) s_miny = int'(bus.y);
        if (int'(bus.y) > s_maxy) s_maxy = int'(bus.y);
        if (bus.x == 8'd67 && bus.y == 7'd37) s_probe = int'(bus.colour);
        s_cnt++;
      end
      if (bus.done === 1'b1) s_dones++;
    end
  end

  task automatic clear_stats();
    s_cnt = 0; s_fx = -1; s_fy = -1; s_lx = -1; s_ly = -1; s_lc = -1;
    s_minx = 999; s_maxx = -1; s_miny = 999; s_maxy = -1; s_probe = -1; s_dones = 0;
  endtask

  // Called just after a rising edge; holds the request for one clock.
  task automatic request(input bit s, input bit so, input logic [3:0] idx,
                         input logic [17:0] g);
    bus.grid      = g;
    bus.start     = s;
    bus.start_one = so;
    bus.cell_idx  = idx;
    model_request(s, so, int'(idx), g);
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.start_one = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.done !== 1'b1 && n < limit);
    chk("done_seen", 32'(bus.done), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.grid      = 18'd0;
    bus.start     = 1'b0;
    bus.start_one = 1'b0;
    bus.cell_idx  = 4'd0;
    reset         = 1'b1;
    clear_stats();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
    reset = 1'b0;

    // Full draw, empty grid.
    clear_stats();
    request(1'b1, 1'b0, 4'd0, 18'd0);
    wait_done(6000);
    chk("empty_count", 32'(s_cnt), 32'd5625);
    chk("empty_first_x", 32'(s_fx), 32'd37);
    chk("empty_first_y", 32'(s_fy), 32'd7);
    chk("empty_last_x", 32'(s_lx), 32'd121);
    chk("empty_last_y", 32'(s_ly), 32'd91);
    chk("empty_last_colour", 32'(s_lc), 32'd7);
    chk("empty_done_pulses", 32'(s_dones), 32'd1);

    // Mixed grid.
    clear_stats();
    request(1'b1, 1'b0, 4'd0, MIXED);
    wait_done(6000);
    chk("mixed_count", 32'(s_cnt), 32'd5625);
    chk("mixed_probe_67_37", 32'(s_probe), 32'd3);
    chk("mixed_cell8_colour", 32'(s_lc), 32'd3);

    // Single cell 5 holding X.
    clear_stats();
    request(1'b0, 1'b1, 4'd5, 18'h00080);
    wait_done(1000);
    chk("one_count", 32'(s_cnt), 32'd625);
    chk("one_min_x", 32'(s_minx), 32'd97);
    chk("one_max_x", 32'(s_maxx), 32'd121);
    chk("one_min_y", 32'(s_miny), 32'd37);
    chk("one_max_y", 32'(s_maxy), 32'd61);
    chk("one_colour", 32'(s_lc), 32'd5);

    // Out-of-range cell index is ignored.
    clear_stats();
    request(1'b0, 1'b1, 4'd9, 18'h00080);
    repeat (20) @(posedge clock);
    #1;
    chk("idx9_count", 32'(s_cnt), 32'd0);
    chk("idx9_busy", 32'(bus.busy), 32'd0);

    // start beats start_one.
    clear_stats();
    request(1'b1, 1'b1, 4'd3, MIXED);
    wait_done(6000);
    chk("both_count", 32'(s_cnt), 32'd5625);
    chk("both_first_x", 32'(s_fx), 32'd37);

    // A second start and a grid change mid-draw have no effect.
    clear_stats();
    request(1'b1, 1'b0, 4'd0, 18'd0);
    repeat (100) @(posedge clock);
    #1;
    request(1'b1, 1'b0, 4'd0, 18'h3FFFF);
    wait_done(6000);
    chk("busy_count", 32'(s_cnt), 32'd5625);
    chk("busy_last_colour", 32'(s_lc), 32'd7);
    chk("busy_done_pulses", 32'(s_dones), 32'd1);

    // Asynchronous reset at pixel 1000.
    clear_stats();
    request(1'b1, 1'b0, 4'd0, 18'd0);
    repeat (1000) @(posedge clock);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_reset_ctrl", 32'({bus.plot, bus.busy, bus.done}), 32'd0);
    chk("async_reset_xy", 32'({bus.x, bus.y}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_stats();
    request(1'b1, 1'b0, 4'd0, MIXED);
    wait_done(6000);
    chk("after_reset_count", 32'(s_cnt), 32'd5625);
    chk("after_reset_first_x", 32'(s_fx), 32'd37);
    chk("after_reset_first_y", 32'(s_fy), 32'd7);

    // Illegal code in cell 8 paints black.
    clear_stats();
    request(1'b1, 1'b0, 4'd0, MIXED | 18'd3);
    wait_done(6000);
    chk("illegal_count", 32'(s_cnt), 32'd5625);
    chk("illegal_cell8_colour", 32'(s_lc), 32'd0);
    chk("illegal_probe_67_37", 32'(s_probe), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
